// File: rtl/bus_datapath_mdu.sv
// rtl/bus_datapath_mdu.sv - single-bus datapath with register file, bus mux and multi-cycle MUL/DIV ALU
module bus_datapath_mdu #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic [NUM_REGS-1:0] Rin,
    input  logic [NUM_REGS-1:0] Rout,
    input  logic                PCin,
    input  logic                PCout,
    input  logic                IncPC,
    input  logic                IRin,
    input  logic                MDRin,
    input  logic                MDRout,
    input  logic                Read,
    input  logic [DATA_W-1:0]   Mdatain,
    input  logic                HIin,
    input  logic                HIout,
    input  logic                LOin,
    input  logic                LOout,
    input  logic                Yin,
    input  logic                Zhighout,
    input  logic                Zlowout,
    input  logic                InPortout,
    input  logic [DATA_W-1:0]   InPort_data,
    input  logic                Cout,
    input  logic [DATA_W-1:0]   C_sign_ext,
    input  logic [3:0]          op,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                div_zero,
    output logic                bus_error,
    output logic [DATA_W-1:0]   bus_out,
    output logic [DATA_W-1:0]   IR_q
);
    localparam int SHW  = $clog2(DATA_W);
    localparam int CW   = $clog2(DATA_W + 1);
    localparam int NSRC = NUM_REGS + 8;

    localparam logic [3:0] OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_SHR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5, OP_NEG = 4'd6, OP_NOT = 4'd7, OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, MULDIV, DONE} state_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] pc, ir, mdr, hi, lo, y, z_hi, z_lo;
    logic [DATA_W-1:0] bus;
    logic [NSRC-1:0]   drv;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, acc_hi, acc_lo;
    logic [DATA_W-1:0] mag_a, mag_b, res_hi, res_lo;
    logic [DATA_W:0]   mul_sum, div_shift, div_diff;
    logic [2*DATA_W-1:0] prod;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

    // Bit 0 is the highest-priority source; two or more set bits is a bus fight.
    assign drv       = {Cout, InPortout, MDRout, LOout, HIout, Zhighout, Zlowout, PCout, Rout};
    assign bus_error = |(drv & (drv - NSRC'(1)));
    assign bus_out   = bus;
    assign IR_q      = ir;

    // Bus mux: later assignments override earlier ones, so lowest-numbered source wins.
    always_comb begin
        bus = '0;
        if (Cout)      bus = C_sign_ext;
        if (InPortout) bus = InPort_data;
        if (MDRout)    bus = mdr;
        if (LOout)     bus = lo;
        if (HIout)     bus = hi;
        if (Zhighout)  bus = z_hi;
        if (Zlowout)   bus = z_lo;
        if (PCout)     bus = pc;
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (Rout[i]) bus = regs[i];
    end

    // Architectural registers loaded from the bus (MDR may take memory data instead).
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            mdr <= '0;
            hi  <= '0;
            lo  <= '0;
            y   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (Rin[i]) regs[i] <= bus;
            if (PCin)       pc <= bus;
            else if (IncPC) pc <= pc + DATA_W'(1);
            if (IRin)  ir  <= bus;
            if (MDRin) mdr <= Read ? Mdatain : bus;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
            if (Yin)   y   <= bus;
        end
    end

    // Iteration step and final result, all from latched operands and accumulators.
    always_comb begin
        mag_a     = magnitude(a_q);
        mag_b     = magnitude(b_q);
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        prod      = {acc_hi, acc_lo};
        res_hi    = '0;
        res_lo    = a_q + b_q;
        case (op_q)
            OP_SUB: res_lo = a_q - b_q;
            OP_AND: res_lo = a_q & b_q;
            OP_OR:  res_lo = a_q | b_q;
            OP_SHR: res_lo = a_q >> b_q[SHW-1:0];
            OP_SHL: res_lo = a_q << b_q[SHW-1:0];
            OP_NEG: res_lo = -b_q;
            OP_NOT: res_lo = ~b_q;
            OP_MUL: {res_hi, res_lo} = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -prod : prod;
            OP_DIV: begin
                if (b_q == '0) begin
                    res_lo = '1;
                    res_hi = a_q;
                end else begin
                    res_lo = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -acc_lo : acc_lo;
                    res_hi = a_q[DATA_W-1] ? -acc_hi : acc_hi;
                end
            end
            default: ;
        endcase
    end

    // ALU sequencer: latch operands on start, iterate MUL/DIV, write Z when leaving DONE.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            z_hi     <= '0;
            z_lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_q      <= y;
                    b_q      <= bus;
                    op_q     <= op;
                    div_zero <= 1'b0;
                    busy     <= 1'b1;
                    acc_hi   <= '0;
                    cnt      <= CW'(DATA_W);
                    if (op == OP_MUL) begin
                        acc_lo <= magnitude(bus);
                        state  <= MULDIV;
                    end else if (op == OP_DIV) begin
                        acc_lo <= magnitude(y);
                        state  <= MULDIV;
                    end else begin
                        state  <= RUN;
                    end
                end
                RUN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                MULDIV: if (cnt == '0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                    if (op_q == OP_MUL) begin
                        acc_hi <= mul_sum[DATA_W:1];
                        acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                    end else if (!div_diff[DATA_W]) begin
                        acc_hi <= div_diff[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    z_hi  <= res_hi;
                    z_lo  <= res_lo;
                    if (op_q == OP_DIV && b_q == '0) div_zero <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
